uart_fifo: RTL and testbench

Memory-mapped 8N1 UART with parametrised TX/RX FIFOs and a runtime-programmable bit divider. It attaches to the SoC's uart_valid/uart_instr/uart_addr/uart_wdata/uart_wstrb/uart_rdata/uart_ready peripheral port. It is the buffered, configurable successor to the single-byte uart peripheral. It serves serial console and boot-loader traffic without CPU stalls on back-to-back bytes.

---
 rtl/uart_fifo_if.sv | 19 +
 rtl/uart_fifo.sv | 187 ++++++++++++++++++
 tb/tb_uart_fifo.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_if.sv
// Peripheral bus bundle for uart_fifo: one request/ready handshake with read and write data.
interface uart_fifo_if;
    logic        uart_valid;
    logic        uart_instr;
    logic [31:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;

    modport master (
        output uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
        input  uart_rdata, uart_ready
    );
    modport slave (
        input  uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
        output uart_rdata, uart_ready
    );
endinterface

// File: rtl/uart_fifo.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, sticky error flags and a runtime bit divider.
module uart_fifo #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    uart_fifo_if.slave bus,
    input  logic       uart_rx,
    output logic       uart_tx
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [15:0] DIV_RST  = 16'(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic        ready_q, ovr_q, ferr_q;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] div_q, div_wr;
    logic [7:0]  txm_q [DEPTH];
    logic [7:0]  rxm_q [DEPTH];
    logic [AW:0] txw_q, txr_q, rxw_q, rxr_q;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        accept, is_wr, is_rd, tx_push, tx_pop, rx_push, rx_push_req, rx_pop;
    logic        ovr_set, ferr_set, stat_clr;
    logic [1:0]  sel;
    logic [6:0]  status;
    logic        unused_bus;

    state_e      txs_q, txs_d, rxs_q, rxs_d;
    logic [15:0] txc_q, txc_d, txdl_q, txdl_d, rxc_q, rxc_d, rxdl_q, rxdl_d;
    logic [2:0]  txb_q, txb_d, rxb_q, rxb_d;
    logic [7:0]  txsh_q, txsh_d, rxsh_q, rxsh_d;
    logic        txo_q, txo_d, brk_q, brk_d;
    logic        s1_q, s2_q, s3_q, rx_fall;

    assign accept   = bus.uart_valid && !ready_q;
    assign is_wr    = accept && (bus.uart_wstrb != 4'b0000);
    assign is_rd    = accept && (bus.uart_wstrb == 4'b0000);
    assign sel      = bus.uart_addr[3:2];
    assign div_wr   = (bus.uart_wdata[15:0] < 16'd4) ? 16'd4 : bus.uart_wdata[15:0];

    assign tx_empty = (txw_q == txr_q);
    assign tx_full  = ((txw_q - txr_q) == FULL_CNT);
    assign rx_empty = (rxw_q == rxr_q);
    assign rx_full  = ((rxw_q - rxr_q) == FULL_CNT);

    // A full FIFO accepts a push only when the same edge frees a slot.
    assign tx_push  = is_wr && (sel == 2'd0) && bus.uart_wstrb[0] && (!tx_full || tx_pop);
    assign rx_pop   = is_rd && (sel == 2'd0) && !rx_empty;
    assign rx_push  = rx_push_req && (!rx_full || rx_pop);
    assign ovr_set  = rx_push_req && rx_full && !rx_pop;
    assign stat_clr = is_rd && (sel == 2'd1);
    assign status   = {(txs_q != IDLE), ferr_q, ovr_q, rx_empty, rx_full, tx_empty, tx_full};

    assign bus.uart_ready = ready_q;
    assign bus.uart_rdata = rdata_q;
    assign uart_tx        = txo_q;
    assign rx_fall        = s3_q && !s2_q;
    assign unused_bus     = ^{bus.uart_instr, bus.uart_addr[31:4], bus.uart_addr[1:0],
                              bus.uart_wdata[31:16]};

    always_comb begin
        rdata_d = '0;
        case (sel)
            2'd0:    rdata_d = rx_empty ? 32'h100 : {24'b0, rxm_q[rxr_q[AW-1:0]]};
            2'd1:    rdata_d = {25'b0, status};
            2'd2:    rdata_d = {16'b0, div_q};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            div_q   <= DIV_RST;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            txw_q   <= '0;
            txr_q   <= '0;
            rxw_q   <= '0;
            rxr_q   <= '0;
        end else begin
            ready_q <= accept;
            rdata_q <= accept ? rdata_d : 32'h0;
            if (is_wr && (sel == 2'd2)) div_q <= div_wr;
            ovr_q   <= (ovr_q  && !stat_clr) || ovr_set;
            ferr_q  <= (ferr_q && !stat_clr) || ferr_set;
            if (tx_push) txw_q <= txw_q + 1'b1;
            if (tx_pop)  txr_q <= txr_q + 1'b1;
            if (rx_push) rxw_q <= rxw_q + 1'b1;
            if (rx_pop)  rxr_q <= rxr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (tx_push) txm_q[txw_q[AW-1:0]] <= bus.uart_wdata[7:0];
        if (rx_push) rxm_q[rxw_q[AW-1:0]] <= rxsh_q;
        txsh_q <= txsh_d;
        txdl_q <= txdl_d;
        rxsh_q <= rxsh_d;
        rxdl_q <= rxdl_d;
    end

    // Transmitter: STOP reloads straight into START so queued bytes leave back-to-back.
    always_comb begin
        txs_d  = txs_q;
        txc_d  = txc_q;
        txb_d  = txb_q;
        txsh_d = txsh_q;
        txdl_d = txdl_q;
        tx_pop = 1'b0;
        case (txs_q)
            IDLE: if (!tx_empty) begin
                tx_pop = 1'b1; txsh_d = txm_q[txr_q[AW-1:0]]; txdl_d = div_q;
                txc_d  = '0;   txs_d  = START;
            end
            START: if (txc_q == txdl_q - 16'd1) begin
                txc_d = '0; txb_d = '0; txs_d = DATA;
            end else txc_d = txc_q + 16'd1;
            DATA: if (txc_q == txdl_q - 16'd1) begin
                txc_d  = '0;
                txsh_d = txsh_q >> 1;
                if (txb_q == 3'd7) txs_d = STOP;
                else               txb_d = txb_q + 3'd1;
            end else txc_d = txc_q + 16'd1;
            STOP: if (txc_q == txdl_q - 16'd1) begin
                txc_d = '0;
                if (!tx_empty) begin
                    tx_pop = 1'b1; txsh_d = txm_q[txr_q[AW-1:0]]; txdl_d = div_q;
                    txs_d  = START;
                end else txs_d = IDLE;
            end else txc_d = txc_q + 16'd1;
            default: txs_d = IDLE;
        endcase
        txo_d = (txs_q == START) ? 1'b0 : (txs_q == DATA) ? txsh_q[0] : 1'b1;
    end

    // Receiver: after a bad stop bit, brk_q holds STOP until the line returns high.
    always_comb begin
        rxs_d       = rxs_q;
        rxc_d       = rxc_q;
        rxb_d       = rxb_q;
        rxsh_d      = rxsh_q;
        rxdl_d      = rxdl_q;
        brk_d       = brk_q;
        rx_push_req = 1'b0;
        ferr_set    = 1'b0;
        case (rxs_q)
            IDLE: if (rx_fall) begin
                rxdl_d = div_q; rxc_d = '0; rxs_d = START;
            end
            START: if (rxc_q == (rxdl_q >> 1) - 16'd1) begin
                rxc_d = '0; rxb_d = '0;
                rxs_d = s2_q ? IDLE : DATA;
            end else rxc_d = rxc_q + 16'd1;
            DATA: if (rxc_q == rxdl_q - 16'd1) begin
                rxc_d  = '0;
                rxsh_d = {s2_q, rxsh_q[7:1]};
                if (rxb_q == 3'd7) rxs_d = STOP;
                else               rxb_d = rxb_q + 3'd1;
            end else rxc_d = rxc_q + 16'd1;
            STOP: if (brk_q) begin
                if (s2_q) begin brk_d = 1'b0; rxs_d = IDLE; end
            end else if (rxc_q == rxdl_q - 16'd1) begin
                rxc_d = '0;
                if (s2_q) begin rx_push_req = 1'b1; rxs_d = IDLE; end
                else begin ferr_set = 1'b1; brk_d = 1'b1; end
            end else rxc_d = rxc_q + 16'd1;
            default: rxs_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            txs_q <= IDLE; txc_q <= '0; txb_q <= '0; txo_q <= 1'b1;
            rxs_q <= IDLE; rxc_q <= '0; rxb_q <= '0; brk_q <= 1'b0;
            s1_q  <= 1'b1; s2_q  <= 1'b1; s3_q  <= 1'b1;
        end else begin
            txs_q <= txs_d; txc_q <= txc_d; txb_q <= txb_d; txo_q <= txo_d;
            rxs_q <= rxs_d; rxc_q <= rxc_d; rxb_q <= rxb_d; brk_q <= brk_d;
            s1_q  <= uart_rx; s2_q <= s1_q; s3_q <= s2_q;
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: register access, TX framing and timing, loopback, RX errors, reset.
module tb_uart_fifo;
    localparam int DEPTH = 16;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rx_drv  = 1'b1;
    logic loop_en = 1'b0;
    logic rx_line, tx_line;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [31:0] r;

    uart_fifo_if bus();

    assign rx_line = loop_en ? tx_line : rx_drv;

    uart_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(868)) dut (
        .clock   (clk),
        .reset   (rst_n),
        .bus     (bus),
        .uart_rx (rx_line),
        .uart_tx (tx_line)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                        output logic [31:0] rd);
        int n;
        @(negedge clk);
        bus.uart_valid = 1'b1;
        bus.uart_addr  = a;
        bus.uart_wdata = d;
        bus.uart_wstrb = st;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.uart_ready !== 1'b1 && n < 4);
        chk("bus_ready", {31'b0, bus.uart_ready}, 32'd1);
        rd = bus.uart_rdata;
        bus.uart_valid = 1'b0;
        bus.uart_wstrb = 4'b0000;
        bus.uart_instr = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(a, d, 4'b1111, dummy);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        xfer(a, 32'h0, 4'b0000, v);
    endtask

    // Waits for a start bit, then samples each bit mid-cell assuming divider 8.
    task automatic cap_frame(output logic [7:0] b, output int t0);
        int n;
        n = 0;
        while (tx_line !== 1'b0 && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cap_start", {31'b0, tx_line}, 32'd0);
        t0 = cyc;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            repeat (8) @(posedge clk);
            #1;
            b[i] = tx_line;
        end
        repeat (8) @(posedge clk);
        #1;
        chk("cap_stop", {31'b0, tx_line}, 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            rx_drv = fr[k];
            repeat (8) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] fa5;
        logic [7:0] cb;
        int         t, tprev;

        bus.uart_valid = 1'b0;
        bus.uart_instr = 1'b0;
        bus.uart_addr  = '0;
        bus.uart_wdata = '0;
        bus.uart_wstrb = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'b0, tx_line}, 32'd1);
        chk("rst_ready", {31'b0, bus.uart_ready}, 32'd0);
        chk("rst_rdata", bus.uart_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        rd(32'h4, r);  chk("stat_reset", r, 32'h0A);
        bus.uart_instr = 1'b1;
        rd(32'h8, r);  chk("div_reset", r, 32'd868);
        rd(32'h0, r);  chk("data_empty", r, 32'h100);
        rd(32'hC, r);  chk("reg3_zero", r, 32'h0);
        chk("tx_idle", {31'b0, tx_line}, 32'd1);

        wr(32'h8, 32'd2);   rd(32'h8, r); chk("div_clamp", r, 32'd4);
        wr(32'h8, 32'd8);   rd(32'h8, r); chk("div_8", r, 32'd8);

        // Single byte: exact start latency and bit pattern.
        fa5 = {1'b1, 8'hA5, 1'b0};
        wr(32'h0, 32'hA5);
        @(posedge clk); #1; chk("a5_pre", {31'b0, tx_line}, 32'd1);
        @(posedge clk); #1; chk("a5_start", {31'b0, tx_line}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("a5_bit", {31'b0, tx_line}, {31'b0, fa5[k]});
            repeat (8) @(posedge clk);
            #1;
        end

        // Three queued bytes must leave with starts exactly 80 clocks apart.
        tprev = 0;
        fork
            begin
                wr(32'h0, 32'h31);
                wr(32'h0, 32'hC4);
                wr(32'h0, 32'h7E);
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    cap_frame(cb, t);
                    case (f)
                        0:       chk("b2b_byte0", {24'b0, cb}, 32'h31);
                        1:       chk("b2b_byte1", {24'b0, cb}, 32'hC4);
                        default: chk("b2b_byte2", {24'b0, cb}, 32'h7E);
                    endcase
                    if (f > 0) chk("b2b_gap", t - tprev, 32'd80);
                    tprev = t;
                end
            end
        join
        repeat (6) @(posedge clk);
        rd(32'h4, r); chk("b2b_txempty", r, 32'h0A);

        // Overfill while the first frame is on the wire.
        fork
            begin
                for (int i = 0; i < DEPTH + 2; i++) wr(32'h0, 32'h20 + i);
                rd(32'h4, r); chk("ovf_status", r, 32'h49);
            end
            begin
                for (int f = 0; f < DEPTH + 1; f++) begin
                    cap_frame(cb, t);
                    chk("ovf_byte", {24'b0, cb}, 32'h20 + f);
                end
            end
        join
        repeat (10) @(posedge clk);
        rd(32'h4, r); chk("ovf_drained", r, 32'h0A);

        // Loopback.
        loop_en = 1'b1;
        wr(32'h0, 32'h3C);
        repeat (120) @(posedge clk);
        rd(32'h0, r); chk("loop_data", r, 32'h03C);
        rd(32'h0, r); chk("loop_empty", r, 32'h100);
        loop_en = 1'b0;

        // RX overrun, sticky clear, frame error.
        for (int i = 0; i < DEPTH + 1; i++) send_rx(8'h40 + 8'(i), 1'b1);
        rd(32'h4, r); chk("rx_overrun", r, 32'h16);
        rd(32'h4, r); chk("rx_ovr_clear", r, 32'h06);
        send_rx(8'h77, 1'b0);
        rd(32'h4, r); chk("rx_frame_err", r, 32'h26);
        rd(32'h0, r); chk("rx_head", r, 32'h040);
        rd(32'h0, r); chk("rx_next", r, 32'h041);

        // Reset mid-frame.
        wr(32'h0, 32'h00);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_tx_low", {31'b0, tx_line}, 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", {31'b0, tx_line}, 32'd1);
        chk("mid_rst_ready", {31'b0, bus.uart_ready}, 32'd0);
        chk("mid_rst_rdata", bus.uart_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rd(32'h4, r); chk("post_rst_stat", r, 32'h0A);
        rd(32'h8, r); chk("post_rst_div", r, 32'd868);
        rd(32'h0, r); chk("post_rst_data", r, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
